// File: rtl/bus_map_pkg.sv
// Shared address map, bus constants and DMA state encoding for the bus
// controller and its address decoder.
package bus_map_pkg;

  localparam logic [15:0] ROM_BASE    = 16'h0000;
  localparam logic [15:0] ROM_LIMIT   = 16'h7FFF;
  localparam logic [15:0] WRAM1_BASE  = 16'hC000;
  localparam logic [15:0] WRAM1_LIMIT = 16'hCFFF;
  localparam logic [15:0] WRAM2_BASE  = 16'hD000;
  localparam logic [15:0] WRAM2_LIMIT = 16'hDFFF;

  localparam logic [15:0] DMA_REG_DEF = 16'hFF46;
  localparam logic [15:0] LED_REG_DEF = 16'hFFFF;
  localparam logic [15:0] DMA_DST_DEF = 16'hFE00;
  localparam int          DMA_LEN_DEF = 160;

  localparam logic [7:0]  OPEN_BUS    = 8'hFF;

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} dma_state_e;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational decode of the memory-side address into per-memory enables;
// mapped_o reports a region hit independent of the strobes.
module addr_decode
  import bus_map_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic        rd_i,
  input  logic        wr_i,
  output logic        rom_en_o,
  output logic        wram1_en_o,
  output logic        wram2_en_o,
  output logic        rom_hit_o,
  output logic        mapped_o
);

  logic rom_hit;
  logic wram1_hit;
  logic wram2_hit;

  assign rom_hit   = in_range(addr_i, ROM_BASE, ROM_LIMIT);
  assign wram1_hit = in_range(addr_i, WRAM1_BASE, WRAM1_LIMIT);
  assign wram2_hit = in_range(addr_i, WRAM2_BASE, WRAM2_LIMIT);

  // The bootrom is read-only, so a write never enables it.
  assign rom_en_o   = rom_hit & rd_i & ~wr_i;
  assign wram1_en_o = wram1_hit & (rd_i | wr_i);
  assign wram2_en_o = wram2_hit & (rd_i | wr_i);
  assign rom_hit_o  = rom_hit;
  assign mapped_o   = rom_hit | wram1_hit | wram2_hit;

endmodule

// File: rtl/bus_dma_ctrl.sv
// Bus controller: muxes the memory bus between the CPU and an OAM-style DMA
// engine, decodes memory enables and holds the LED register.
module bus_dma_ctrl
  import bus_map_pkg::*;
#(
  parameter logic [15:0] DMA_REG = DMA_REG_DEF,
  parameter logic [15:0] LED_REG = LED_REG_DEF,
  parameter logic [15:0] DMA_DST = DMA_DST_DEF,
  parameter int          DMA_LEN = DMA_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic        rom_en,
  output logic        wram1_en,
  output logic        wram2_en,
  output logic        dma_active,
  output logic [7:0]  led
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  led_q, led_d;
  logic        src_mapped_q, src_mapped_d;
  logic        own_q;

  logic        bus_rd;
  logic        bus_wr;
  logic        rom_hit;
  logic        mapped;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  assign src_addr = {src_hi_q, 8'h00} + {8'h00, index_q};
  assign dst_addr = DMA_DST + {8'h00, index_q};

  always_comb begin
    mem_a    = cpu_a;
    mem_dout = cpu_dout;
    bus_rd   = cpu_rd;
    bus_wr   = cpu_wr;
    unique case (state_q)
      READ: begin
        mem_a  = src_addr;
        bus_rd = 1'b1;
        bus_wr = 1'b0;
      end
      WAIT: begin
        mem_a  = src_addr;
        bus_rd = 1'b0;
        bus_wr = 1'b0;
      end
      WRITE: begin
        mem_a    = dst_addr;
        mem_dout = byte_q;
        bus_rd   = 1'b0;
        bus_wr   = 1'b1;
      end
      default: ;
    endcase
    // Reset silences the bus so nothing is enabled or written while held.
    if (rst) begin
      bus_rd = 1'b0;
      bus_wr = 1'b0;
    end
  end

  addr_decode u_decode (
    .addr_i     (mem_a),
    .rd_i       (bus_rd),
    .wr_i       (bus_wr),
    .rom_en_o   (rom_en),
    .wram1_en_o (wram1_en),
    .wram2_en_o (wram2_en),
    .rom_hit_o  (rom_hit),
    .mapped_o   (mapped)
  );

  assign mem_wr = bus_wr & ~rom_hit;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    src_hi_d     = src_hi_q;
    byte_d       = byte_q;
    src_mapped_d = src_mapped_q;
    led_d        = led_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr && cpu_a == LED_REG) led_d = cpu_dout;
        if (cpu_wr && cpu_a == DMA_REG) begin
          src_hi_d = cpu_dout;
          index_d  = 8'h00;
          state_d  = READ;
        end
      end
      READ: begin
        // mem_a carries the source address here, so the shared decode
        // doubles as the source-mapped check.
        src_mapped_d = mapped;
        state_d      = WAIT;
      end
      WAIT: begin
        byte_d  = src_mapped_q ? mem_din : OPEN_BUS;
        state_d = WRITE;
      end
      WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= 8'h00;
      src_hi_q     <= 8'h00;
      byte_q       <= 8'h00;
      src_mapped_q <= 1'b0;
      led_q        <= 8'h00;
      own_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      src_hi_q     <= src_hi_d;
      byte_q       <= byte_d;
      src_mapped_q <= src_mapped_d;
      led_q        <= led_d;
      own_q        <= (state_q == IDLE);
    end
  end

  // Read data lags the request by a cycle, so ownership is judged one cycle back.
  assign cpu_din    = own_q ? mem_din : OPEN_BUS;
  assign dma_active = (state_q != IDLE);
  assign led        = led_q;

endmodule

// File: tb/tb_bus_dma_ctrl.sv
// Randomized self-checking bench for bus_dma_ctrl with a byte-level model of
// the address space and a whole-transfer view of each DMA.
module tb_bus_dma_ctrl;

  localparam logic [15:0] DST = 16'hD000;
  localparam int          LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = 8'h5C;
  logic        rom_en;
  logic        wram1_en;
  logic        wram2_en;
  logic        dma_active;
  logic [7:0]  led;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rom_m [0:32767];
  logic [7:0] w1_m  [0:4095];
  logic [7:0] w2_m  [0:4095];
  logic [7:0] ref_w [0:8191];
  logic [7:0] led_ref;

  always #5 clk = ~clk;

  bus_dma_ctrl #(
    .DMA_REG (16'hFF46),
    .LED_REG (16'hFFFF),
    .DMA_DST (DST),
    .DMA_LEN (LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_din    (cpu_din),
    .mem_a      (mem_a),
    .mem_dout   (mem_dout),
    .mem_wr     (mem_wr),
    .mem_din    (mem_din),
    .rom_en     (rom_en),
    .wram1_en   (wram1_en),
    .wram2_en   (wram2_en),
    .dma_active (dma_active),
    .led        (led)
  );

  // Synchronous memories; an undriven bus returns a non-FF junk value.
  always @(posedge clk) begin
    mem_din <= 8'h5C;
    if (rom_en) mem_din <= rom_m[mem_a[14:0]];
    else if (wram1_en) begin
      if (mem_wr) w1_m[mem_a[11:0]] <= mem_dout;
      else        mem_din <= w1_m[mem_a[11:0]];
    end else if (wram2_en) begin
      if (mem_wr) w2_m[mem_a[11:0]] <= mem_dout;
      else        mem_din <= w2_m[mem_a[11:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 unmapped, 1 ROM, 2 WRAM1, 3 WRAM2
  function automatic int region(input logic [15:0] a);
    if (a <= 16'h7FFF) return 1;
    if (a >= 16'hC000 && a <= 16'hCFFF) return 2;
    if (a >= 16'hD000 && a <= 16'hDFFF) return 3;
    return 0;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    int r;
    r = region(a);
    if (r == 1) return rom_m[a[14:0]];
    if (r >= 2) return ref_w[a[12:0]];
    return 8'hFF;
  endfunction

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    int r;
    r = region(a);
    @(negedge clk);
    cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
    #1;
    check_eq("wr_en", 32'({rom_en, wram1_en, wram2_en}), 32'({1'b0, r == 2, r == 3}));
    check_eq("wr_strobe", 32'(mem_wr), 32'(r != 1));
    @(negedge clk);
    cpu_wr = 1'b0;
    if (r >= 2) ref_w[a[12:0]] = d;
    if (a == 16'hFFFF) led_ref = d;
    check_eq("led", 32'(led), 32'(led_ref));
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    int r;
    r = region(a);
    @(negedge clk);
    cpu_a = a; cpu_rd = 1'b1;
    #1;
    check_eq("rd_en", 32'({rom_en, wram1_en, wram2_en}), 32'({r == 1, r == 2, r == 3}));
    @(negedge clk);
    d = cpu_din;
    cpu_rd = 1'b0;
    if (r != 0) check_eq($sformatf("rd_%04h", a), 32'(d), 32'(ref_rd(a)));
  endtask

  // noise: 0 quiet, 1 random CPU traffic, 2 fixed blocked-access pattern.
  // rst_at: 0 for a full transfer, else the DMA cycle in which rst is raised.
  task automatic run_dma(input logic [7:0] page, input int noise, input int rst_at);
    int cyc;
    int done;
    logic [15:0] s;
    logic [15:0] t;
    logic [7:0] v;
    logic [7:0] rb;
    @(negedge clk);
    cpu_a = 16'hFF46; cpu_dout = page; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
    check_eq("dma_start", 32'(dma_active), 32'd1);
    cyc = 1;
    while (dma_active === 1'b1 && cyc <= 200) begin
      if (cyc >= 2) check_eq("dma_cpu_din", 32'(cpu_din), 32'hFF);
      if (cyc == rst_at) rst = 1'b1;
      else if (noise == 2) begin
        if (cyc == 2) begin cpu_a = 16'hFFFF; cpu_dout = 8'h5A; cpu_wr = 1'b1; end
        if (cyc == 3) begin cpu_a = 16'hC000; cpu_rd = 1'b1; end
        if (cyc == 5) begin cpu_a = 16'hFF46; cpu_dout = 8'hE0; cpu_wr = 1'b1; end
      end else if (noise == 1) begin
        cpu_dout = 8'($urandom);
        case ($urandom_range(0, 3))
          0: begin cpu_a = 16'hFFFF; cpu_wr = 1'b1; end
          1: begin cpu_a = 16'hFF46; cpu_wr = 1'b1; end
          2: begin cpu_a = 16'($urandom); cpu_rd = 1'b1; end
          default: begin cpu_a = 16'hD000 + 16'($urandom_range(0, 7)); cpu_wr = 1'b1; end
        endcase
      end
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0; rst = 1'b0;
      cyc++;
    end
    if (rst_at > 0) begin
      check_eq("dma_rst_cycles", 32'(cyc - 1), 32'(rst_at));
      done = (rst_at - 1) / 3;
      led_ref = 8'h00;
    end else begin
      check_eq("dma_cycles", 32'(cyc - 1), 32'(3 * LEN));
      check_eq("dma_end_din", 32'(cpu_din), 32'hFF);
      done = LEN;
    end
    check_eq("dma_led", 32'(led), 32'(led_ref));
    for (int i = 0; i < done; i++) begin
      s = {page, 8'h00} + 16'(i);
      t = DST + 16'(i);
      v = (region(s) != 0) ? ref_rd(s) : 8'hFF;
      if (region(t) >= 2) ref_w[t[12:0]] = v;
    end
    for (int i = 0; i < LEN; i++) cpu_read(DST + 16'(i), rb);
  endtask

  initial begin
    logic [7:0] d;
    logic [15:0] a;
    int k;
    for (int i = 0; i < 32768; i++) rom_m[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++) ref_w[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) begin
      w1_m[i] = ref_w[i];
      w2_m[i] = ref_w[4096 + i];
    end
    led_ref = 8'h00;

    // Reset held with live CPU strobes: nothing may be enabled or written.
    rst = 1'b1; cpu_a = 16'hC000; cpu_dout = 8'hEE; cpu_rd = 1'b0; cpu_wr = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_en", 32'({rom_en, wram1_en, wram2_en}), 32'd0);
      check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    end
    rst = 1'b0; cpu_wr = 1'b0;
    check_eq("rst_led", 32'(led), 32'h00);
    check_eq("rst_dma", 32'(dma_active), 32'd0);

    cpu_read(16'h0010, d);
    cpu_write(16'hFFFF, 8'hA5);
    check_eq("led_a5", 32'(led), 32'hA5);
    cpu_write(16'hFFFE, 8'h3C);
    check_eq("led_keep", 32'(led), 32'hA5);
    cpu_write(16'h0123, 8'h77);

    cpu_write(16'hC000, 8'h11);
    cpu_write(16'hC001, 8'h22);
    cpu_write(16'hC002, 8'h33);
    cpu_write(16'hC003, 8'h44);
    run_dma(8'hC0, 2, 0);
    check_eq("blocked_led", 32'(led), 32'hA5);
    cpu_read(16'hD000, d); check_eq("copy0", 32'(d), 32'h11);
    cpu_read(16'hD003, d); check_eq("copy3", 32'(d), 32'h44);

    run_dma(8'hE0, 0, 0);
    cpu_read(16'hD001, d); check_eq("unmapped_src", 32'(d), 32'hFF);

    run_dma(8'hC0, 0, 5);
    cpu_read(16'hD000, d); check_eq("rst_mid_d0", 32'(d), 32'h11);
    cpu_read(16'hD001, d); check_eq("rst_mid_d1", 32'(d), 32'hFF);

    // Reset and DMA trigger in the same cycle: reset wins.
    cpu_write(16'hFFFF, 8'h96);
    @(negedge clk);
    rst = 1'b1; cpu_a = 16'hFF46; cpu_dout = 8'hC0; cpu_wr = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_wr = 1'b0;
    led_ref = 8'h00;
    check_eq("rst_vs_trig_dma", 32'(dma_active), 32'd0);
    check_eq("rst_vs_trig_led", 32'(led), 32'h00);

    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: begin
          a = ($urandom_range(0, 1) != 0) ? 16'hC000 : 16'hD000;
          cpu_write(a + 16'($urandom_range(0, 15)), 8'($urandom));
        end
        3: cpu_write(16'($urandom_range(0, 32767)), 8'($urandom));
        4, 5: begin
          case ($urandom_range(0, 2))
            0: a = 16'($urandom_range(0, 32767));
            1: a = 16'hC000 + 16'($urandom_range(0, 15));
            default: a = 16'hD000 + 16'($urandom_range(0, 15));
          endcase
          cpu_read(a, d);
        end
        6: cpu_write(16'hFFFF, 8'($urandom));
        default: begin
          case ($urandom_range(0, 3))
            0: d = 8'hC0 + 8'($urandom_range(0, 31));
            1: d = 8'($urandom_range(0, 127));
            2: d = 8'hE0 + 8'($urandom_range(0, 31));
            default: d = 8'hD0;
          endcase
          if ($urandom_range(0, 3) == 0)
            run_dma(d, 0, 3 * $urandom_range(0, LEN - 1) + 1 + $urandom_range(0, 1));
          else
            run_dma(d, 1, 0);
        end
      endcase
    end

    for (int i = 0; i < 16; i++) begin
      cpu_read(16'hC000 + 16'(i), d);
      cpu_read(16'hD000 + 16'(i), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_dma_ctrl.md
Name: bus_dma_ctrl

Overview:
- Bus controller between the CPU core and the memory-mapped resources: bootrom, WRAM bank 1, WRAM bank 2 and the LED register.
- Decodes the shared address bus and generates per-memory enables.
- Owns an OAM-style DMA engine. A CPU write to the DMA register takes the bus away from the CPU and copies DMA_LEN bytes from {N,8'h00} to DMA_DST, one byte at a time.
- Replaces the free-running enables and LED logic in the top level.

Parameters:
- DMA_REG, 16'hFF46, CPU write address that triggers DMA.
- LED_REG, 16'hFFFF, CPU write address of the LED register.
- DMA_DST, 16'hFE00, destination base address.
- DMA_LEN, 160, bytes per transfer (1..256).

Ports:
- clk  in  1  CPU clock (4.19 MHz domain).
- rst  in  1  synchronous, active-high reset.
- cpu_a  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_rd  in  1  CPU read strobe.
- cpu_wr  in  1  CPU write strobe.
- cpu_din  out  8  read data returned to the CPU.
- mem_a  out  16  address to memories.
- mem_dout  out  8  write data to memories.
- mem_wr  out  1  write strobe to memories.
- mem_din  in  8  read data from the enabled memory (1-cycle synchronous latency).
- rom_en  out  1  bootrom enable.
- wram1_en  out  1  WRAM1 enable.
- wram2_en  out  1  WRAM2 enable.
- dma_active  out  1  DMA owns the bus.
- led  out  8  LED register.

Behaviour:
- Address map, combinational decode of mem_a:
  - ROM 0000-7FFF.
  - WRAM1 C000-CFFF.
  - WRAM2 D000-DFFF.
  - Anything else is unmapped: no enable asserted.
- Enables are asserted only while (mem_rd|mem_wr). rom_en is never asserted on a write; mem_wr to ROM is suppressed.
- Reset values: dma_active=0, led=8'h00, FSM=IDLE, index=0, own_q=1, all enables=0, mem_wr=0.
- CPU owns the bus (FSM IDLE): mem_a=cpu_a, mem_dout=cpu_dout, mem_wr=cpu_wr, mem_rd=cpu_rd.
- CPU write to LED_REG loads led at the clock edge. CPU write to DMA_REG loads src_hi=cpu_dout, clears index and moves to READ; dma_active=1 from the next cycle.
- own_q is a register: 1 if the CPU owned the bus in the previous cycle. cpu_din = own_q ? mem_din : 8'hFF.
- FSM, 3 cycles per byte, DMA_LEN*3 cycles total:
  - IDLE: wait for the trigger.
  - READ: mem_a={src_hi,8'h00}+index, mem_rd=1, mem_wr=0. Register src_mapped. Go to WAIT.
  - WAIT: latch byte_q = src_mapped ? mem_din : 8'hFF. Go to WRITE.
  - WRITE: mem_a=DMA_DST+index, mem_dout=byte_q, mem_wr=1. If index==DMA_LEN-1, go to IDLE (dma_active=0 next cycle); else index++ and go to READ.
- While dma_active:
  - CPU reads return 8'hFF.
  - CPU writes are dropped, including writes to LED_REG, and writes to DMA_REG (no retrigger, no restart).
- Address arithmetic is 16-bit and wraps modulo 2^16. index is 8 bits wide.
- A destination in unmapped space produces mem_wr pulses with no enable, so no memory changes.
- rst asserted mid-DMA aborts on the next edge: FSM=IDLE, dma_active=0, led cleared, and destination bytes already written stay written.
- rst and a DMA_REG write in the same cycle: reset wins.

Decomposition:
- bus_map_pkg holds:
  - region base/limit constants: ROM, WRAM1, WRAM2, DMA_REG, LED_REG defaults;
  - the FSM state enum {IDLE, READ, WAIT, WRITE};
  - OPEN_BUS=8'hFF.
- Sub-module addr_decode: combinational, mem_a/rd/wr -> rom_en, wram1_en, wram2_en, mapped. It is reused for the src_mapped check.

Test Plan:
- Reset: hold rst 2 cycles -> led=00, dma_active=0, all enables 0. CPU read of 0x0010 -> rom_en=1, and cpu_din=ROM data one cycle later.
- LED: CPU writes 0xA5 to FFFF -> led=A5 the next cycle. A write to FFFE leaves led=A5.
- DMA copy (DMA_DST=D000, DMA_LEN=4): preload C000-C003=11,22,33,44, CPU writes 0xC0 to FF46 -> dma_active high for exactly 12 cycles; D000-D003 read back 11,22,33,44.
- CPU blocked: during that DMA, CPU writes 0x5A to FFFF and reads C000 -> led unchanged, cpu_din=FF.
- Retrigger and unmapped source: a second FF46 write mid-DMA is ignored (total 12 cycles). DMA from 0xE0 (unmapped) -> D000-D003 = FF.
- Reset mid-DMA: assert rst at cycle 5 of a transfer -> dma_active=0 next cycle; D000 is written, D001-D003 keep their old values.
